// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding instruction fetch with a one-entry skid buffer, and the IF/ID register.
module fetch_stage #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               id_valid_o,
    output logic [PC_W-1:0]    id_pc_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [6:0]         id_opcode_o
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

    state_t             state, state_nx;
    logic [PC_W-1:0]    pc, target;
    logic [INSTR_W-1:0] skid;
    logic               hold_up, deliver, capture;

    assign target      = {redirect_pc_i[PC_W-1:2], 2'b00};
    assign hold_up     = stall_i && id_valid_o;
    assign imem_addr   = pc;
    assign id_opcode_o = id_instr_o[6:0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= REQ;
        else        state <= state_nx;

    // A redirect that lands on an accepted request must still swallow that request's response.
    always_comb begin
        state_nx = state;
        case (state)
            REQ:     state_nx = imem_ready ? (redirect_i ? DROP : WAIT) : REQ;
            WAIT:    state_nx = imem_rvalid ? ((hold_up && !redirect_i) ? HOLD : REQ) : (redirect_i ? DROP : WAIT);
            HOLD:    state_nx = (stall_i && !redirect_i) ? HOLD : REQ;
            DROP:    state_nx = imem_rvalid ? REQ : DROP;
            default: state_nx = REQ;
        endcase
    end

    always_comb begin
        imem_req = rst_n && state == REQ;
        deliver  = !redirect_i && ((state == WAIT && imem_rvalid && !hold_up) || (state == HOLD && !stall_i));
        capture  = !redirect_i && state == WAIT && imem_rvalid && hold_up;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc   <= RESET_PC;
            skid <= NOP_INSTR;
        end else begin
            if (redirect_i)   pc <= target;
            else if (deliver) pc <= pc + PC_W'(4);
            if (capture) skid <= imem_rdata;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            id_valid_o <= 1'b0;
            id_pc_o    <= '0;
            id_instr_o <= NOP_INSTR;
        end else if (redirect_i) begin
            id_valid_o <= 1'b0;
            id_instr_o <= NOP_INSTR;
        end else if (!hold_up) begin
            id_valid_o <= deliver;
            id_instr_o <= deliver ? (state == HOLD ? skid : imem_rdata) : NOP_INSTR;
            if (deliver) id_pc_o <= pc;
        end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the opcode decoder/controller. It owns the PC, issues one outstanding request at a time to instruction memory, and absorbs variable memory latency with a one-entry skid buffer. It presents the fetched instruction, its PC and a valid flag to the decode stage, and also drives the 7-bit opcode consumed by the controller. It supports a stall from downstream and a redirect (taken branch) that flushes in-flight fetches.

Parameters:
PC_W, 32, width of PC and memory address
INSTR_W, 32, instruction width (fixed RV32; opcode is bits [6:0])
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  request valid to instruction memory
imem_addr  out  PC_W  request address (= pc)
imem_ready  in  1  memory accepts request this cycle (req & ready = accepted)
imem_rvalid  in  1  read data valid (one response per accepted request, at least 1 cycle after acceptance)
imem_rdata  in  INSTR_W  read data
stall_i  in  1  decode stage cannot take a new instruction; hold IF/ID
redirect_i  in  1  taken branch/jump; flush and refetch
redirect_pc_i  in  PC_W  redirect target; bits [1:0] ignored, treated as 00
id_valid_o  out  1  IF/ID holds a real instruction
id_pc_o  out  PC_W  PC of id_instr_o
id_instr_o  out  INSTR_W  instruction to decode
id_opcode_o  out  7  id_instr_o[6:0], combinational, feeds controller Opcode

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, imem_req=0 while in reset, id_valid_o=0, id_instr_o=NOP_INSTR, id_pc_o=0, skid empty. The first cycle after release drives imem_req=1 with imem_addr=RESET_PC.
- imem_req is 1 only in state REQ. imem_addr=pc at all times.
- FSM states: REQ, WAIT, HOLD, DROP.
- REQ:
  - ready=1, no redirect: go to WAIT.
  - redirect=1, ready=0: pc<=redirect_pc and stay in REQ. Changing the address of an unaccepted request is legal.
  - redirect=1 and ready=1: the old-pc request was accepted. pc<=redirect_pc, go to DROP.
- WAIT, on rvalid:
  - stall_i=0 or id_valid_o=0: load IF/ID (instr=rdata, pc=pc, valid=1), pc<=pc+4, go to REQ.
  - stall_i=1 and id_valid_o=1: capture rdata and pc into skid, go to HOLD.
- HOLD: when stall_i=0, move skid into IF/ID, pc<=pc+4, go to REQ.
- DROP: wait for rvalid, discard the data, go to REQ. No IF/ID load.
- Redirect in WAIT: pc<=redirect_pc, go to DROP. If rvalid arrives the same cycle, the data is discarded and the FSM goes to REQ instead.
- Redirect in HOLD: the skid is discarded, pc<=redirect_pc, go to REQ.
- IF/ID register:
  - redirect_i=1 overrides everything: valid<=0, instr<=NOP_INSTR. Redirect wins over stall.
  - Else stall_i=1 and valid=1: hold.
  - Else a new instruction this cycle: load it.
  - Else: bubble (valid<=0, instr<=NOP_INSTR, pc unchanged).
- PC arithmetic is modulo 2^PC_W: 0xFFFF_FFFC+4 = 0x0000_0000.
- Throughput: with ready=1 and rvalid one cycle later, one instruction every 2 cycles. Only one request is outstanding at a time.
- Reset mid-WAIT/DROP: the state is lost. The environment must also reset memory, and any late rvalid arriving in REQ is ignored.

Test Plan:
1. Reset release, memory ready=1, rvalid 1 cycle after acceptance returning addr^0xA5A5_0000 -> imem_addr 0,4,8 on successive REQ cycles. id_pc_o/id_instr_o = 0/0xA5A5_0000, 4/0xA5A5_0004, each valid one cycle then bubble. id_opcode_o=instr[6:0].
2. Memory holds ready=0 for 3 cycles at pc=0x10 -> imem_req stays 1 and addr stays 0x10 for 4 cycles. The fetch completes normally.
3. IF/ID valid (pc 0x8), stall_i=1 for 4 cycles while rvalid returns 0x0000_0033 for pc 0xC -> IF/ID holds pc 0x8, FSM in HOLD, no imem_req. Stall drops -> next cycle id_pc_o=0xC, id_instr_o=0x33, then imem_addr=0x10.
4. Redirect to 0x100 during WAIT for pc 0x20 -> IF/ID flushed (valid 0, NOP). The response for 0x20 is dropped, next request addr=0x100, and the first valid id_pc_o=0x100.
5. Redirect to 0x43 with imem_ready=1 in the same REQ cycle -> DROP entered, one response discarded, next imem_addr=0x40.
6. Redirect to 0xFFFF_FFFC, then fetch -> next imem_addr=0x0000_0000. Assert rst_n=0 mid-WAIT -> outputs immediately valid=0, instr=NOP, and the first post-reset addr=RESET_PC.
